jtag_reg_master: RTL
====================

JTAG_REG_MASTER -- requirements
Module: jtag_reg_master

Interface
REQ-001 Parameter HALT_TIMEOUT, 8'd255, max cycles to wait for halted_i after halt_req_o rises.
REQ-002 Parameter RETRY_MAX, 3, max write re-issues when an ex-stage write steals the register-file write port.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-005 req_valid  input  1  debug request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  5  target GPR index.
REQ-009 req_data  input  32  write data.
REQ-010 resp_valid  output  1  response present.
REQ-011 resp_ready  input  1  response consumed.
REQ-012 resp_data  output  32  read data; for writes, the written value.
REQ-013 resp_err  output  1  1 = request failed.
REQ-014 halt_req_o  output  1  core halt request.
REQ-015 halted_i  input  1  core reports halted.
REQ-016 ex_we_i  input  1  ex-stage register write enable, observed only for contention detection.
REQ-017 jtag_we_o / jtag_addr_o / jtag_data_o  output  1 / 5 / 32  register-file debug port write enable, address, write data.
REQ-018 jtag_data_i  input  32  register-file debug port read data, combinational from jtag_addr_o.

Function
REQ-019 FSM states: IDLE, HALT, ACCESS, VERIFY, RESP.
REQ-020 IDLE: req_ready=1; request accepted on req_valid&&req_ready; req_we/addr/data latched in that cycle.
REQ-021 Accepted request with addr==0: go directly to RESP; read gives resp_data=0, resp_err=0; write gives resp_err=1; no halt, no port activity.
REQ-022 Accepted request with addr!=0: go to HALT; halt_req_o=1 from the next cycle; timeout counter cleared.
REQ-023 HALT: on halted_i=1 go to ACCESS; counter increments each cycle with halted_i=0; counter reaching HALT_TIMEOUT goes to RESP with resp_err=1.
REQ-024 ACCESS read: jtag_addr_o=latched addr, jtag_we_o=0; jtag_data_i captured into resp_data at the end of the same cycle; then RESP, resp_err=0.
REQ-025 ACCESS write: jtag_we_o=1 for exactly one cycle with latched addr/data.
REQ-026 Write contention: ex_we_i=1 in that cycle means the write is dropped by the register file; ACCESS repeats next cycle and the retry count increments.
REQ-027 Write contention limit: after RETRY_MAX dropped attempts, go to RESP with resp_err=1.
REQ-028 Write without contention: go to VERIFY if JTAG_REG_VERIFY_EN is defined, otherwise RESP with resp_err=0.
REQ-029 halt_req_o SHALL be 1 only in HALT, ACCESS and VERIFY.
REQ-030 RESP: req_ready=0 and resp_valid=1; resp_data/resp_err stay stable until resp_ready=1, then IDLE next cycle.
REQ-031 Throughput: a new request is accepted no earlier than the cycle after the RESP handshake.
REQ-032 jtag_we_o=0 in every state except the ACCESS write cycle.

Reset
REQ-033 rst=0 at posedge clk forces IDLE from any state, including mid-ACCESS.
REQ-034 Reset values: req_ready=1, resp_valid=0, resp_data=0, resp_err=0, halt_req_o=0, jtag_we_o=0, jtag_addr_o=0, jtag_data_o=0; counters=0.
REQ-035 A request in flight at reset is discarded without a response.

Configuration
REQ-036 Macro JTAG_REG_VERIFY_EN defined: VERIFY drives jtag_addr_o for one cycle with jtag_we_o=0.
REQ-037 VERIFY compare: jtag_data_i is compared with the latched data; a match goes to RESP with resp_err=0; a mismatch goes to RESP with resp_err=1 and resp_data=jtag_data_i.
REQ-038 Macro absent: VERIFY state and comparator are not compiled; writes complete as in REQ-028.

Verification
REQ-039 Read x5 holding 32'hDEADBEEF, halted_i high 2 cycles after halt_req_o -> resp_valid with resp_data=32'hDEADBEEF, resp_err=0, halt_req_o low in RESP.
REQ-040 Write x0 with 32'h1234 -> RESP within 2 cycles, resp_err=1, halt_req_o never asserted, jtag_we_o never asserted.
REQ-041 Write x7=32'hA5A5A5A5 with ex_we_i=1 on the first 2 ACCESS cycles -> 3 jtag_we_o pulses, resp_err=0; ex_we_i held high -> RETRY_MAX pulses, resp_err=1.
REQ-042 halted_i held 0 -> resp_err=1 after HALT_TIMEOUT cycles in HALT; jtag_we_o never asserted.
REQ-043 resp_ready held 0 for 10 cycles, then rst=0 mid-RESP -> resp_valid stable and req_ready=0 during the stall; all outputs at reset values after reset, no response.
REQ-044 With JTAG_REG_VERIFY_EN and a model that corrupts bit 0 -> write x3=32'h1 returns resp_err=1, resp_data=32'h0.

Source files
------------

// File: rtl/jtag_reg_master.sv
// Debug register-file master: halts the core, reads or writes one GPR
// through the register-file debug port, and returns a single response.
// Optional: `define JTAG_REG_VERIFY_EN to read back and compare each write.
// Ports: clk/rst (sync, active-low); req_* request channel; resp_* response
// channel; halt_req_o/halted_i core halt handshake; ex_we_i ex-stage write
// enable (contention sense); jtag_* register-file debug port.
module jtag_reg_master #(
  parameter logic [7:0]  HALT_TIMEOUT = 8'd255,
  parameter int unsigned RETRY_MAX    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        halt_req_o,
  input  logic        halted_i,
  input  logic        ex_we_i,
  output logic        jtag_we_o,
  output logic [4:0]  jtag_addr_o,
  output logic [31:0] jtag_data_o,
  input  logic [31:0] jtag_data_i
);

  localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
`ifdef JTAG_REG_VERIFY_EN
    S_VERIFY,
`endif
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  halt_cnt_q, halt_cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      halt_cnt_q <= '0;
      retry_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      halt_cnt_q <= halt_cnt_d;
      retry_q    <= retry_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    halt_cnt_d = halt_cnt_q;
    retry_d    = retry_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          addr_d     = req_addr;
          data_d     = req_data;
          halt_cnt_d = '0;
          retry_d    = '0;
          rdata_d    = req_we ? req_data : '0;
          err_d      = 1'b0;
          // x0 is hardwired: reads return zero, writes are refused
          if (req_addr == 5'd0) begin
            state_d = S_RESP;
            err_d   = req_we;
          end else begin
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (halted_i) begin
          state_d = S_ACCESS;
        end else begin
          halt_cnt_d = halt_cnt_q + 8'd1;
          if ({1'b0, halt_cnt_q} + 9'd1 >= {1'b0, HALT_TIMEOUT}) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = jtag_data_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (ex_we_i) begin
          // ex stage owns the write port this cycle; our write is lost
          retry_d = retry_q + 8'd1;
          if ({1'b0, retry_q} + 9'd1 >= {1'b0, RETRY_LIM}) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end else begin
`ifdef JTAG_REG_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef JTAG_REG_VERIFY_EN
      S_VERIFY: begin
        state_d = S_RESP;
        if (jtag_data_i != data_q) begin
          err_d   = 1'b1;
          rdata_d = jtag_data_i;
        end
      end
`endif
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    halt_req_o  = 1'b0;
    jtag_we_o   = 1'b0;
    jtag_addr_o = '0;
    jtag_data_o = '0;
    unique case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_HALT: halt_req_o = 1'b1;
      S_ACCESS: begin
        halt_req_o  = 1'b1;
        jtag_addr_o = addr_q;
        jtag_we_o   = we_q;
        jtag_data_o = we_q ? data_q : '0;
      end
`ifdef JTAG_REG_VERIFY_EN
      S_VERIFY: begin
        halt_req_o  = 1'b1;
        jtag_addr_o = addr_q;
      end
`endif
      S_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_data = rdata_q;
  assign resp_err  = err_q;

endmodule
